// File: rtl/tlb_pkg.sv
// Shared TLB definitions: page-size codes, TLB instruction encodings,
// INVTLB op codes, the entry record and the vppn comparison helper.
package tlb_pkg;

    localparam int TLBNUM_DEFAULT = 16;
    localparam int IDXW           = 4;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_2M = 6'd21;

    typedef enum logic [2:0] {
        TLB_SRCH = 3'd0,
        TLB_RD   = 3'd1,
        TLB_WR   = 3'd2,
        TLB_FILL = 3'd3,
        TLB_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [4:0] {
        INV_ALL0       = 5'd0,
        INV_ALL1       = 5'd1,
        INV_GLOBAL     = 5'd2,
        INV_NONGLOBAL  = 5'd3,
        INV_ASID       = 5'd4,
        INV_ASID_VA    = 5'd5,
        INV_VA         = 5'd6
    } invtlb_op_e;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    // A 2MB page ignores the low nine vppn bits; anything else compares all 19.
    function automatic logic vppn_match(input logic [18:0] ent_vppn,
                                        input logic [5:0]  ent_ps,
                                        input logic [18:0] key_vppn);
        if (ent_ps == PS_2M)
            return ent_vppn[18:9] == key_vppn[18:9];
        else
            return ent_vppn == key_vppn;
    endfunction

endpackage

// File: rtl/tlb_entry_match.sv
// Per-entry combinational comparator: does this entry translate the key?
module tlb_entry_match
    import tlb_pkg::*;
(
    input  logic        e,
    input  logic        g,
    input  logic [9:0]  asid,
    input  logic [18:0] vppn,
    input  logic [5:0]  ps,
    input  logic [18:0] key_vppn,
    input  logic [9:0]  key_asid,
    output logic        hit
);

    // Valid, address-space visible (global or same ASID), and page number agrees.
    always_comb begin
        hit = e & (g | (asid == key_asid)) & vppn_match(vppn, ps, key_vppn);
    end

endmodule

// File: rtl/tlb.sv
// Fully associative TLB with two search ports, one read port, one write port
// and INVTLB invalidation. INVTLB is only built when TLB_INVTLB_EN is defined;
// otherwise invtlb_valid/invtlb_op are accepted and ignored.
module tlb
    import tlb_pkg::*;
#(
    parameter int TLBNUM = TLBNUM_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [18:0] s0_vppn,
    input  logic        s0_va_bit12,
    input  logic [9:0]  s0_asid,
    output logic        s0_found,
    output logic [3:0]  s0_index,
    output logic [19:0] s0_ppn,
    output logic [5:0]  s0_ps,
    output logic [1:0]  s0_plv,
    output logic [1:0]  s0_mat,
    output logic        s0_d,
    output logic        s0_v,

    input  logic [18:0] s1_vppn,
    input  logic        s1_va_bit12,
    input  logic [9:0]  s1_asid,
    output logic        s1_found,
    output logic [3:0]  s1_index,
    output logic [19:0] s1_ppn,
    output logic [5:0]  s1_ps,
    output logic [1:0]  s1_plv,
    output logic [1:0]  s1_mat,
    output logic        s1_d,
    output logic        s1_v,

    input  logic        invtlb_valid,
    input  logic [4:0]  invtlb_op,

    input  logic        we,
    input  logic [3:0]  w_index,
    input  logic        w_e,
    input  logic [5:0]  w_ps,
    input  logic [18:0] w_vppn,
    input  logic [9:0]  w_asid,
    input  logic        w_g,
    input  logic [19:0] w_ppn0,
    input  logic [1:0]  w_plv0,
    input  logic [1:0]  w_mat0,
    input  logic        w_d0,
    input  logic        w_v0,
    input  logic [19:0] w_ppn1,
    input  logic [1:0]  w_plv1,
    input  logic [1:0]  w_mat1,
    input  logic        w_d1,
    input  logic        w_v1,

    input  logic [3:0]  r_index,
    output logic        r_e,
    output logic [18:0] r_vppn,
    output logic [5:0]  r_ps,
    output logic [9:0]  r_asid,
    output logic        r_g,
    output logic [19:0] r_ppn0,
    output logic [1:0]  r_plv0,
    output logic [1:0]  r_mat0,
    output logic        r_d0,
    output logic        r_v0,
    output logic [19:0] r_ppn1,
    output logic [1:0]  r_plv1,
    output logic [1:0]  r_mat1,
    output logic        r_d1,
    output logic        r_v1
);

    tlb_entry_t entries [TLBNUM];
    tlb_entry_t new_entry;
    logic [TLBNUM-1:0] s0_hit;
    logic [TLBNUM-1:0] s1_hit;
    logic [TLBNUM-1:0] inv_sel;

    for (genvar i = 0; i < TLBNUM; i++) begin : g_match
        tlb_entry_match u_s0 (
            .e(entries[i].e), .g(entries[i].g), .asid(entries[i].asid),
            .vppn(entries[i].vppn), .ps(entries[i].ps),
            .key_vppn(s0_vppn), .key_asid(s0_asid), .hit(s0_hit[i])
        );
        tlb_entry_match u_s1 (
            .e(entries[i].e), .g(entries[i].g), .asid(entries[i].asid),
            .vppn(entries[i].vppn), .ps(entries[i].ps),
            .key_vppn(s1_vppn), .key_asid(s1_asid), .hit(s1_hit[i])
        );
    end

    // Pack the write port into one entry record.
    always_comb begin
        new_entry = '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                      ppn0: w_ppn0, plv0: w_plv0, mat0: w_mat0, d0: w_d0, v0: w_v0,
                      ppn1: w_ppn1, plv1: w_plv1, mat1: w_mat1, d1: w_d1, v1: w_v1};
    end

`ifdef TLB_INVTLB_EN
    // Decide which entries an INVTLB op kills; operands come from the s1 key.
    always_comb begin
        inv_sel = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            case (invtlb_op)
                INV_ALL0, INV_ALL1: inv_sel[i] = 1'b1;
                INV_GLOBAL:         inv_sel[i] = entries[i].g;
                INV_NONGLOBAL:      inv_sel[i] = ~entries[i].g;
                INV_ASID:           inv_sel[i] = ~entries[i].g & (entries[i].asid == s1_asid);
                INV_ASID_VA:        inv_sel[i] = ~entries[i].g & (entries[i].asid == s1_asid)
                                                 & vppn_match(entries[i].vppn, entries[i].ps, s1_vppn);
                INV_VA:             inv_sel[i] = (entries[i].g | (entries[i].asid == s1_asid))
                                                 & vppn_match(entries[i].vppn, entries[i].ps, s1_vppn);
                default:            inv_sel[i] = 1'b0;
            endcase
        end
    end
`else
    logic unused_invtlb;
    assign unused_invtlb = ^{invtlb_valid, invtlb_op};
    assign inv_sel = '0;
`endif

    // Entry storage: invalidate first, then the write lands so it wins on a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) entries[i] <= '0;
        end else begin
`ifdef TLB_INVTLB_EN
            if (invtlb_valid) begin
                for (int i = 0; i < TLBNUM; i++)
                    if (inv_sel[i]) entries[i].e <= 1'b0;
            end
`endif
            if (we) entries[w_index] <= new_entry;
        end
    end

    // Port 0 lookup: lowest matching index, then odd/even page pick; zeros on miss.
    always_comb begin
        tlb_entry_t ent;
        logic odd;
        s0_found = 1'b0;
        s0_index = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (s0_hit[i]) begin
                s0_found = 1'b1;
                s0_index = IDXW'(i);
            end
        end
        ent = s0_found ? entries[s0_index] : '0;
        odd = (ent.ps == PS_2M) ? s0_vppn[8] : s0_va_bit12;
        s0_ps  = ent.ps;
        s0_ppn = odd ? ent.ppn1 : ent.ppn0;
        s0_plv = odd ? ent.plv1 : ent.plv0;
        s0_mat = odd ? ent.mat1 : ent.mat0;
        s0_d   = odd ? ent.d1   : ent.d0;
        s0_v   = odd ? ent.v1   : ent.v0;
    end

    // Port 1 lookup: same rules as port 0.
    always_comb begin
        tlb_entry_t ent;
        logic odd;
        s1_found = 1'b0;
        s1_index = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (s1_hit[i]) begin
                s1_found = 1'b1;
                s1_index = IDXW'(i);
            end
        end
        ent = s1_found ? entries[s1_index] : '0;
        odd = (ent.ps == PS_2M) ? s1_vppn[8] : s1_va_bit12;
        s1_ps  = ent.ps;
        s1_ppn = odd ? ent.ppn1 : ent.ppn0;
        s1_plv = odd ? ent.plv1 : ent.plv0;
        s1_mat = odd ? ent.mat1 : ent.mat0;
        s1_d   = odd ? ent.d1   : ent.d0;
        s1_v   = odd ? ent.v1   : ent.v0;
    end

    // Read port shows current storage, so a same-cycle write is not yet visible.
    always_comb begin
        {r_e, r_vppn, r_ps, r_asid, r_g,
         r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
         r_ppn1, r_plv1, r_mat1, r_d1, r_v1} = entries[r_index];
    end

endmodule

// File: tb/tb_tlb.sv
// Directed self-checking bench for tlb. Expectations for INVTLB follow
// whether TLB_INVTLB_EN is defined for the build.
module tb_tlb;

    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] s0_vppn, s1_vppn;
    logic        s0_va_bit12, s1_va_bit12;
    logic [9:0]  s0_asid, s1_asid;
    logic        s0_found, s1_found;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_ppn, s1_ppn;
    logic [5:0]  s0_ps, s1_ps;
    logic [1:0]  s0_plv, s1_plv, s0_mat, s1_mat;
    logic        s0_d, s1_d, s0_v, s1_v;
    logic        invtlb_valid;
    logic [4:0]  invtlb_op;
    logic        we, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [3:0]  w_index, r_index;
    logic [5:0]  w_ps, r_ps;
    logic [18:0] w_vppn, r_vppn;
    logic [9:0]  w_asid, r_asid;
    logic [19:0] w_ppn0, w_ppn1, r_ppn0, r_ppn1;
    logic [1:0]  w_plv0, w_mat0, w_plv1, w_mat1, r_plv0, r_mat0, r_plv1, r_mat1;
    logic        r_e, r_g, r_d0, r_v0, r_d1, r_v1;

    int compared = 0;
    int mismatched = 0;
    logic exp_e [16];

`ifdef TLB_INVTLB_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    tlb dut (
        .clk(clk), .reset(reset),
        .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
        .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
        .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .we(we), .w_index(w_index), .w_e(w_e), .w_ps(w_ps), .w_vppn(w_vppn),
        .w_asid(w_asid), .w_g(w_g),
        .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
        .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
        .r_g(r_g),
        .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
        .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the write port from the next falling edge through one rising edge.
    // Pages: even plv=1 mat=1 d=0, odd plv=2 mat=2 d=1, both valid.
    task automatic applyStimulus(input logic [3:0] idx, input logic e,
                                 input logic [18:0] vppn, input logic [5:0] ps,
                                 input logic [9:0] asid, input logic g,
                                 input logic [19:0] ppn0, input logic [19:0] ppn1);
        @(negedge clk);
        we = 1'b1; w_index = idx; w_e = e; w_vppn = vppn; w_ps = ps;
        w_asid = asid; w_g = g;
        w_ppn0 = ppn0; w_plv0 = 2'd1; w_mat0 = 2'd1; w_d0 = 1'b0; w_v0 = 1'b1;
        w_ppn1 = ppn1; w_plv1 = 2'd2; w_mat1 = 2'd2; w_d1 = 1'b1; w_v1 = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; invtlb_valid = 1'b0; invtlb_op = '0;
        w_index = '0; w_e = 0; w_ps = '0; w_vppn = '0; w_asid = '0; w_g = 0;
        w_ppn0 = '0; w_plv0 = '0; w_mat0 = '0; w_d0 = 0; w_v0 = 0;
        w_ppn1 = '0; w_plv1 = '0; w_mat1 = '0; w_d1 = 0; w_v1 = 0;
        s0_vppn = '0; s0_va_bit12 = 0; s0_asid = '0;
        s1_vppn = '0; s1_va_bit12 = 0; s1_asid = '0;
        r_index = '0;
        for (int i = 0; i < 16; i++) exp_e[i] = 1'b0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("reset_s0_found", 32'(s0_found), 32'd0);
        checkOutput("reset_s0_ppn", 32'(s0_ppn), 32'd0);
        checkOutput("reset_r_e", 32'(r_e), 32'd0);
        checkOutput("reset_r_vppn", 32'(r_vppn), 32'd0);

        // Write idx 3; search and read in the same cycle still see the old state.
        s1_vppn = 19'h12345; s1_va_bit12 = 1'b1; s1_asid = 10'd5; r_index = 4'd3;
        @(negedge clk);
        we = 1'b1; w_index = 4'd3; w_e = 1'b1; w_vppn = 19'h12345; w_ps = 6'd12;
        w_asid = 10'd5; w_g = 1'b0;
        w_ppn0 = 20'hAAAAA; w_plv0 = 2'd1; w_mat0 = 2'd1; w_d0 = 1'b0; w_v0 = 1'b1;
        w_ppn1 = 20'hBBBBB; w_plv1 = 2'd2; w_mat1 = 2'd2; w_d1 = 1'b1; w_v1 = 1'b1;
        #1;
        checkOutput("same_cycle_s1_found", 32'(s1_found), 32'd0);
        checkOutput("same_cycle_r_e", 32'(r_e), 32'd0);
        @(posedge clk);
        #1 we = 1'b0;
        exp_e[3] = 1'b1;
        #1;
        checkOutput("w3_s1_found", 32'(s1_found), 32'd1);
        checkOutput("w3_s1_index", 32'(s1_index), 32'd3);
        checkOutput("w3_s1_ppn_odd", 32'(s1_ppn), 32'hBBBBB);
        checkOutput("w3_s1_ps", 32'(s1_ps), 32'd12);
        checkOutput("w3_s1_plv_odd", 32'(s1_plv), 32'd2);
        checkOutput("w3_s1_d_odd", 32'(s1_d), 32'd1);
        checkOutput("w3_r_ppn0", 32'(r_ppn0), 32'hAAAAA);
        s1_va_bit12 = 1'b0;
        #1;
        checkOutput("w3_s1_ppn_even", 32'(s1_ppn), 32'hAAAAA);
        checkOutput("w3_s1_mat_even", 32'(s1_mat), 32'd1);
        s1_asid = 10'd6;
        #1;
        checkOutput("w3_asid_miss_found", 32'(s1_found), 32'd0);
        checkOutput("w3_asid_miss_ppn", 32'(s1_ppn), 32'd0);
        checkOutput("w3_asid_miss_index", 32'(s1_index), 32'd0);

        // 2MB global page at idx 7.
        applyStimulus(4'd7, 1'b1, 19'h40000, 6'd21, 10'd0, 1'b1, 20'h11111, 20'h22222);
        exp_e[7] = 1'b1;
        s0_vppn = 19'h401FF; s0_va_bit12 = 1'b0; s0_asid = 10'd9;
        #1;
        checkOutput("2m_found", 32'(s0_found), 32'd1);
        checkOutput("2m_index", 32'(s0_index), 32'd7);
        checkOutput("2m_ppn_odd", 32'(s0_ppn), 32'h22222);
        checkOutput("2m_ps", 32'(s0_ps), 32'd21);
        s0_vppn = 19'h400FF; s0_va_bit12 = 1'b1;
        #1;
        checkOutput("2m_ppn_even", 32'(s0_ppn), 32'h11111);
        s0_vppn = 19'h40200;
        #1;
        checkOutput("2m_out_of_range", 32'(s0_found), 32'd0);

        // Duplicate key at idx 9: lowest index must win.
        applyStimulus(4'd9, 1'b1, 19'h12345, 6'd12, 10'd5, 1'b0, 20'hCCCCC, 20'hDDDDD);
        exp_e[9] = 1'b1;
        s1_vppn = 19'h12345; s1_va_bit12 = 1'b1; s1_asid = 10'd5;
        #1;
        checkOutput("multi_hit_index", 32'(s1_index), 32'd3);
        checkOutput("multi_hit_ppn", 32'(s1_ppn), 32'hBBBBB);

        // INVTLB op 5 on asid 2 / vppn 0xABC: only the non-global entry dies.
        applyStimulus(4'd1, 1'b1, 19'h00ABC, 6'd12, 10'd2, 1'b0, 20'h00001, 20'h00002);
        applyStimulus(4'd2, 1'b1, 19'h00ABC, 6'd12, 10'd2, 1'b1, 20'h00003, 20'h00004);
        exp_e[1] = 1'b1; exp_e[2] = 1'b1;
        s1_vppn = 19'h00ABC; s1_asid = 10'd2; invtlb_op = 5'd5; invtlb_valid = 1'b1;
        @(posedge clk);
        #1 invtlb_valid = 1'b0;
        if (INV_EN) exp_e[1] = 1'b0;
        r_index = 4'd1;
        #1;
        checkOutput("inv5_idx1_e", 32'(r_e), 32'(exp_e[1]));
        r_index = 4'd2;
        #1;
        checkOutput("inv5_idx2_e", 32'(r_e), 32'd1);
        r_index = 4'd3;
        #1;
        checkOutput("inv5_idx3_e", 32'(r_e), 32'd1);

        // Op 31 is a no-op in any build.
        invtlb_op = 5'd31; invtlb_valid = 1'b1;
        @(posedge clk);
        #1 invtlb_valid = 1'b0;
        r_index = 4'd7;
        #1;
        checkOutput("inv31_idx7_e", 32'(r_e), 32'd1);

        // INVTLB op 0 coincident with a write to idx 4: the write survives.
        invtlb_op = 5'd0; invtlb_valid = 1'b1;
        applyStimulus(4'd4, 1'b1, 19'h00777, 6'd12, 10'd3, 1'b0, 20'h00005, 20'h00006);
        invtlb_valid = 1'b0;
        if (INV_EN) for (int i = 0; i < 16; i++) exp_e[i] = 1'b0;
        exp_e[4] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r_index = 4'(i);
            #1;
            checkOutput($sformatf("inv0_we_r_e[%0d]", i), 32'(r_e), 32'(exp_e[i]));
        end
        s0_vppn = 19'h00777; s0_va_bit12 = 1'b0; s0_asid = 10'd3;
        #1;
        checkOutput("idx4_s0_found", 32'(s0_found), 32'd1);
        checkOutput("idx4_s0_index", 32'(s0_index), 32'd4);

        // Reset with a write pending: reset wins, everything cleared.
        @(negedge clk);
        reset = 1'b1;
        we = 1'b1; w_index = 4'd5; w_e = 1'b1; w_vppn = 19'h00777; w_asid = 10'd3; w_g = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            r_index = 4'(i);
            #1;
            checkOutput($sformatf("post_reset_r_e[%0d]", i), 32'(r_e), 32'd0);
        end
        checkOutput("post_reset_s0_found", 32'(s0_found), 32'd0);
        checkOutput("post_reset_s0_ppn", 32'(s0_ppn), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
